// File: rtl/itch_msg_framer_if.sv
// Byte-stream bundle between the UDP payload parser,
// the ITCH message framer and the order-book decoders.
interface itch_msg_framer_if;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_last;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_first;
   logic        out_last;
   logic [7:0]  out_type;
   logic [7:0]  out_idx;
   logic [15:0] out_len;
   logic        seq_valid;
   logic [63:0] seq_num;
   logic [15:0] msg_count;
   logic        err_trunc;
   logic        err_len;

   modport master (
      output in_valid,
      output in_data,
      output in_last,
      input  out_valid,
      input  out_data,
      input  out_first,
      input  out_last,
      input  out_type,
      input  out_idx,
      input  out_len,
      input  seq_valid,
      input  seq_num,
      input  msg_count,
      input  err_trunc,
      input  err_len
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_last,
      output out_valid,
      output out_data,
      output out_first,
      output out_last,
      output out_type,
      output out_idx,
      output out_len,
      output seq_valid,
      output seq_num,
      output msg_count,
      output err_trunc,
      output err_len
   );
endinterface

// File: rtl/itch_msg_framer.sv
// Splits a UDP payload into length-prefixed ITCH messages.
// Define MOLD_HDR_EN to strip a leading MoldUDP64 header.
module itch_msg_framer #(
   parameter int MAX_MSG_LEN = 64
) (
   input logic         clk,
   input logic         reset,
   itch_msg_framer_if.slave bus
);

   typedef enum logic [2:0] {
      HDR,
      LEN_HI,
      LEN_LO,
      BODY,
      DROP
   } state_t;

`ifdef MOLD_HDR_EN
   localparam state_t START = HDR;
`else
   localparam state_t START = LEN_HI;
`endif

   localparam logic [15:0] MAX_LEN = 16'(MAX_MSG_LEN);

   state_t      state;
   state_t      state_n;
   logic [7:0]  len_hi;
   logic [7:0]  len_hi_n;
   logic [7:0]  idx;
   logic [7:0]  idx_n;

   logic        valid_r;
   logic        valid_n;
   logic [7:0]  data_r;
   logic [7:0]  data_n;
   logic        first_r;
   logic        first_n;
   logic        last_r;
   logic        last_n;
   logic [7:0]  type_r;
   logic [7:0]  type_n;
   logic [7:0]  oidx_r;
   logic [7:0]  oidx_n;
   logic [15:0] len_r;
   logic [15:0] len_n;
   logic        trunc_r;
   logic        trunc_n;
   logic        elen_r;
   logic        elen_n;

`ifdef MOLD_HDR_EN
   logic [4:0]  hdr_cnt;
   logic [4:0]  hdr_cnt_n;
   logic        seqv_r;
   logic        seqv_n;
   logic [63:0] seq_r;
   logic [63:0] seq_n;
   logic [15:0] cnt_r;
   logic [15:0] cnt_n;
`endif

   logic [15:0] len_w;
   logic        at_end;

   assign len_w  = {len_hi, bus.in_data};
   assign at_end = ({8'd0, idx} == (len_r - 16'd1));

   always_comb begin
      state_n  = state;
      len_hi_n = len_hi;
      idx_n    = idx;
      valid_n  = 1'b0;
      data_n   = data_r;
      first_n  = 1'b0;
      last_n   = 1'b0;
      type_n   = type_r;
      oidx_n   = oidx_r;
      len_n    = len_r;
      trunc_n  = 1'b0;
      elen_n   = 1'b0;
`ifdef MOLD_HDR_EN
      hdr_cnt_n = hdr_cnt;
      seqv_n    = 1'b0;
      seq_n     = seq_r;
      cnt_n     = cnt_r;
`endif

      if (bus.in_valid) begin
         unique case (state)
`ifdef MOLD_HDR_EN
            HDR: begin
               hdr_cnt_n = hdr_cnt + 5'd1;
               if (hdr_cnt >= 5'd10 && hdr_cnt <= 5'd17)
                  seq_n = {seq_r[55:0], bus.in_data};
               if (hdr_cnt == 5'd18)
                  cnt_n[15:8] = bus.in_data;
               if (hdr_cnt == 5'd19) begin
                  cnt_n[7:0] = bus.in_data;
                  seqv_n     = 1'b1;
                  hdr_cnt_n  = 5'd0;
                  state_n    = LEN_HI;
               end
               if (bus.in_last) begin
                  hdr_cnt_n = 5'd0;
                  trunc_n   = (hdr_cnt != 5'd19);
               end
            end
`endif
            LEN_HI: begin
               len_hi_n = bus.in_data;
               state_n  = LEN_LO;
            end
            LEN_LO: begin
               if (len_w == 16'd0) begin
                  state_n = LEN_HI;
               end else if (len_w > MAX_LEN) begin
                  elen_n  = 1'b1;
                  state_n = DROP;
               end else begin
                  len_n   = len_w;
                  idx_n   = 8'd0;
                  state_n = BODY;
               end
               trunc_n = bus.in_last;
            end
            BODY: begin
               valid_n = 1'b1;
               data_n  = bus.in_data;
               oidx_n  = idx;
               first_n = (idx == 8'd0);
               if (idx == 8'd0)
                  type_n = bus.in_data;
               last_n  = at_end | bus.in_last;
               trunc_n = bus.in_last & ~at_end;
               idx_n   = idx + 8'd1;
               if (at_end)
                  state_n = LEN_HI;
            end
            DROP: begin
               state_n = DROP;
            end
            default: begin
               state_n = START;
            end
         endcase

         // End of datagram always re-arms the parser.
         if (bus.in_last)
            state_n = START;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= START;
         len_hi  <= '0;
         idx     <= '0;
         valid_r <= 1'b0;
         data_r  <= '0;
         first_r <= 1'b0;
         last_r  <= 1'b0;
         type_r  <= '0;
         oidx_r  <= '0;
         len_r   <= '0;
         trunc_r <= 1'b0;
         elen_r  <= 1'b0;
`ifdef MOLD_HDR_EN
         hdr_cnt <= '0;
         seqv_r  <= 1'b0;
         seq_r   <= '0;
         cnt_r   <= '0;
`endif
      end else begin
         state   <= state_n;
         len_hi  <= len_hi_n;
         idx     <= idx_n;
         valid_r <= valid_n;
         data_r  <= data_n;
         first_r <= first_n;
         last_r  <= last_n;
         type_r  <= type_n;
         oidx_r  <= oidx_n;
         len_r   <= len_n;
         trunc_r <= trunc_n;
         elen_r  <= elen_n;
`ifdef MOLD_HDR_EN
         hdr_cnt <= hdr_cnt_n;
         seqv_r  <= seqv_n;
         seq_r   <= seq_n;
         cnt_r   <= cnt_n;
`endif
      end
   end

   assign bus.out_valid = valid_r;
   assign bus.out_data  = data_r;
   assign bus.out_first = first_r;
   assign bus.out_last  = last_r;
   assign bus.out_type  = type_r;
   assign bus.out_idx   = oidx_r;
   assign bus.out_len   = len_r;
   assign bus.err_trunc = trunc_r;
   assign bus.err_len   = elen_r;

`ifdef MOLD_HDR_EN
   assign bus.seq_valid = seqv_r;
   assign bus.seq_num   = seq_r;
   assign bus.msg_count = cnt_r;
`else
   assign bus.seq_valid = 1'b0;
   assign bus.seq_num   = 64'd0;
   assign bus.msg_count = 16'd0;
`endif

endmodule

// File: tb/tb_itch_msg_framer.sv
// Randomized bench for itch_msg_framer: datagrams are built from
// message descriptions and the expected output events follow from them.
module tb_itch_msg_framer;

   localparam int MAX = 64;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   itch_msg_framer_if bus ();

   itch_msg_framer #(.MAX_MSG_LEN(MAX)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic        v, f, l, tr, el, sv;
      logic [7:0]  d, t, i;
      logic [15:0] n;
      logic [63:0] s;
      logic [15:0] c;
   } ev_t;

   ev_t        exp_q[$];
   logic [7:0] byte_q[$];
   logic       last_q[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] hold_idx = 8'd0;
   ev_t        me;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic ev_t ev_none();
      ev_t e;
      e = '{default: '0};
      return e;
   endfunction

   task automatic put(input logic [7:0] b, input logic l);
      byte_q.push_back(b);
      last_q.push_back(l);
   endtask

   task automatic add_hdr(input logic [63:0] s, input logic [15:0] c,
                          input int last_at);
      logic [7:0] b;
      ev_t e;
      for (int k = 0; k < 20; k++) begin
         if (last_at >= 0 && k > last_at) break;
         if (k < 10) b = 8'($urandom);
         else if (k < 18) b = s[8*(17-k) +: 8];
         else if (k == 18) b = c[15:8];
         else b = c[7:0];
         put(b, k == last_at);
         if (k == 19) begin
            e = ev_none(); e.sv = 1; e.s = s; e.c = c;
            exp_q.push_back(e);
         end else if (k == last_at) begin
            e = ev_none(); e.tr = 1;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic start_dg();
`ifdef MOLD_HDR_EN
      add_hdr({$urandom, $urandom}, 16'($urandom), -1);
`endif
   endtask

   task automatic add_msg(input int len, input int cut_at, input int abort_at,
                          input bit last_end, input bit fill_en,
                          input logic [7:0] fill);
      logic [15:0] n;
      logic [7:0] b, t;
      bit cut, fin;
      ev_t e;
      n = 16'(len);
      t = 8'd0;
      put(n[15:8], 1'b0);
      put(n[7:0], 1'b0);
      for (int i = 0; i < len; i++) begin
         if (i == abort_at) break;
         b = fill_en ? fill : 8'($urandom);
         if (i == 0) t = b;
         cut = (i == cut_at);
         fin = (i == len - 1);
         put(b, cut | (fin & last_end));
         e = ev_none();
         e.v = 1; e.d = b; e.t = t; e.i = 8'(i); e.n = n;
         e.f = (i == 0); e.l = fin | cut; e.tr = cut & ~fin;
         exp_q.push_back(e);
         if (cut) break;
      end
   endtask

   task automatic add_zero();
      put(8'd0, 1'b0);
      put(8'd0, 1'b0);
   endtask

   task automatic add_over(input int len, input int drop_n);
      logic [15:0] n;
      ev_t e;
      n = 16'(len);
      put(n[15:8], 1'b0);
      put(n[7:0], 1'b0);
      e = ev_none(); e.el = 1;
      exp_q.push_back(e);
      for (int k = 0; k < drop_n; k++)
         put(8'($urandom), k == drop_n - 1);
   endtask

   task automatic add_lenlo_trunc(input int len);
      logic [15:0] n;
      ev_t e;
      n = 16'(len);
      put(n[15:8], 1'b0);
      put(n[7:0], 1'b1);
      e = ev_none(); e.tr = 1;
      exp_q.push_back(e);
   endtask

   task automatic send_all(input int maxgap);
      while (byte_q.size() > 0) begin
         bus.in_data  = byte_q.pop_front();
         bus.in_last  = last_q.pop_front();
         bus.in_valid = 1'b1;
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
         bus.in_last  = 1'b0;
         repeat ($urandom_range(maxgap)) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic drain(input string tag);
      repeat (4) @(posedge clk);
      #1;
      chk(tag, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic chk_zero(input string tag);
      chk(tag, {bus.out_valid, bus.out_first, bus.out_last, bus.out_data,
                bus.out_type, bus.out_idx, bus.out_len, bus.seq_valid,
                bus.err_trunc, bus.err_len}, 64'd0);
      chk({tag, "_seq"}, {bus.seq_num}, 64'd0);
      chk({tag, "_cnt"}, {48'd0, bus.msg_count}, 64'd0);
   endtask

   always @(negedge clk) begin
      if (bus.out_valid | bus.err_trunc | bus.err_len | bus.seq_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected", {bus.out_valid, bus.err_trunc, bus.err_len,
                               bus.seq_valid}, 64'd0);
         end else begin
            me = exp_q.pop_front();
            chk("flags",
                {bus.out_valid, bus.out_first, bus.out_last,
                 bus.err_trunc, bus.err_len, bus.seq_valid},
                {me.v, me.f, me.l, me.tr, me.el, me.sv});
            if (me.v) begin
               chk("data", bus.out_data, me.d);
               chk("idx", bus.out_idx, me.i);
               chk("type", bus.out_type, me.t);
               chk("len", bus.out_len, me.n);
               hold_idx = me.i;
            end
            if (me.sv) begin
               chk("seq_num", bus.seq_num, me.s);
               chk("msg_count", bus.msg_count, me.c);
            end
         end
      end else begin
         chk("idx_hold", bus.out_idx, hold_idx);
      end
      if (!reset) hold_idx = 8'd0;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int r, n, len;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'd0;
      bus.in_last  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      reset = 1'b1;
      @(posedge clk);
      #1;

`ifdef MOLD_HDR_EN
      add_hdr(64'h1234, 16'd1, -1);
`endif
      add_msg(12, -1, -1, 1, 1, 8'h41);
      send_all(0);
      drain("single");

      start_dg();
      add_msg(3, -1, -1, 0, 0, 8'd0);
      add_msg(2, -1, -1, 1, 0, 8'd0);
      send_all(3);
      drain("gaps");

      start_dg();
      add_msg(10, 4, -1, 0, 0, 8'd0);
      start_dg();
      add_msg(5, -1, -1, 1, 0, 8'd0);
      send_all(0);
      drain("trunc");

      start_dg();
      add_over(300, 4);
      start_dg();
      add_msg(7, -1, -1, 1, 0, 8'd0);
      send_all(1);
      drain("oversize");

      start_dg();
      add_zero();
      add_msg(1, -1, -1, 1, 0, 8'd0);
`ifdef MOLD_HDR_EN
      add_hdr(64'hDEAD_BEEF_0BAD_F00D, 16'd0, 19);
      add_hdr(64'h55, 16'd3, 7);
`endif
      send_all(1);
      drain("zero_hb");

      start_dg();
      add_msg(MAX, -1, -1, 1, 0, 8'd0);
      start_dg();
      add_over(MAX + 1, 1);
      start_dg();
      add_lenlo_trunc(5);
      start_dg();
      add_msg(2, -1, -1, 0, 0, 8'd0);
      put(8'($urandom), 1'b1);
      send_all(1);
      drain("bounds");

      start_dg();
      add_msg(10, -1, 5, 0, 0, 8'd0);
      send_all(0);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk_zero("mid_reset");
      reset = 1'b1;
      @(posedge clk);
      #1;
      start_dg();
      add_msg(6, -1, -1, 1, 0, 8'd0);
      send_all(1);
      drain("after_reset");

      for (int g = 0; g < 40; g++) begin
`ifdef MOLD_HDR_EN
         if ($urandom_range(7) == 0) begin
            add_hdr({$urandom, $urandom}, 16'($urandom),
                    $urandom_range(19));
            continue;
         end
`endif
         start_dg();
         n = $urandom_range(4);
         for (int m = 0; m < n; m++) begin
            if ($urandom_range(9) < 8)
               add_msg($urandom_range(MAX, 1), -1, -1, 0, 0, 8'd0);
            else
               add_zero();
         end
         r = $urandom_range(6);
         len = $urandom_range(MAX, 2);
         if (r < 3) add_msg(len, -1, -1, 1, 0, 8'd0);
         else if (r == 3) add_msg(len, $urandom_range(len - 2), -1, 0, 0, 8'd0);
         else if (r == 4) add_over($urandom_range(65535, MAX + 1),
                                   $urandom_range(5, 1));
         else if (r == 5) add_lenlo_trunc(len);
         else put(8'($urandom), 1'b1);
      end
      send_all(2);
      drain("random");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/itch_msg_framer.md
# itch_msg_framer

Splits the UDP payload byte stream produced by the packet header parser into individual NASDAQ ITCH messages. It sits directly downstream of the ETH/IP/UDP parsing stage and consumes only the bytes presented while that stage is in its PAYLOAD phase. It optionally strips a MoldUDP64 header first. It then walks the 2-byte big-endian length prefixes and emits each message body as a framed byte stream for the order-book decoders.

## Interface
- MAX_MSG_LEN, 64: largest accepted message body in bytes (1..255).
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  payload byte valid. No backpressure; a byte is accepted every cycle this is high.
- in_data  in  8  payload byte.
- in_last  in  1  qualifies the final payload byte of the datagram.
- out_valid  out  1  message byte valid.
- out_data  out  8  message byte.
- out_first  out  1  first byte of a message (the ITCH type byte).
- out_last  out  1  final byte of a message, or the truncation point.
- out_type  out  8  message type; equals out_data on out_first and is held afterwards.
- out_idx  out  8  byte index within the message body, 0-based.
- out_len  out  16  declared body length of the current message.
- seq_valid  out  1  one-cycle pulse: seq_num/msg_count updated (MOLD_HDR_EN only).
- seq_num  out  64  MoldUDP64 sequence number.
- msg_count  out  16  MoldUDP64 message count.
- err_trunc  out  1  one-cycle pulse: datagram ended mid-header or mid-message.
- err_len  out  1  one-cycle pulse: length prefix exceeded MAX_MSG_LEN.

## Operation
- States: HDR, LEN_HI, LEN_LO, BODY, DROP. The start state is HDR when MOLD_HDR_EN is defined, otherwise LEN_HI.
- State advances only on an accepted byte (in_valid=1). With in_valid=0, the state holds and out_valid=0.
- HDR: consumes 20 bytes using a 5-bit counter.
  - Bytes 10..17 shift into seq_num, MSB first.
  - Bytes 18..19 form msg_count.
  - After byte 19, go to LEN_HI.
- LEN_HI: capture the high byte of the length, go to LEN_LO.
- LEN_LO: form len = {hi, in_data}.
  - len=0: return to LEN_HI; no output.
  - len>MAX_MSG_LEN: pulse err_len, go to DROP.
  - Otherwise: latch out_len, clear the index, go to BODY.
- BODY: emit each byte with out_idx = index.
  - out_first when index=0.
  - out_last when index=len-1; then go to LEN_HI.
- DROP: discard bytes until in_last.
- in_last handling, applied on the accepted byte after the rules above:
  - In any state, the next state becomes the start state.
  - In LEN_HI: normal end. In HDR when byte 19 is the last byte: normal end (heartbeat datagram).
  - In LEN_LO, in DROP, and in HDR before byte 19: pulse err_trunc, except DROP, which emits no error.
  - In BODY before index len-1: emit the byte with out_last=1 and pulse err_trunc.
  - In BODY at index len-1: normal out_last, no error.
- Width rules:
  - Length compare is 16-bit unsigned.
  - The index counter is 8-bit and cannot wrap, because len ≤ MAX_MSG_LEN ≤ 255.

## Timing
- All outputs are registered. Accepting a byte at cycle N produces out_* and the error pulses at cycle N+1.
- seq_valid pulses at N+1 after header byte 19 is accepted. seq_num and msg_count then hold until the next header.
- out_valid, out_first, out_last, seq_valid, err_trunc and err_len are single-cycle per accepted byte. out_type, out_len and out_idx hold between bytes.
- Reset values: every output is 0, state is the start state, counters are 0.
- Reset asserted mid-message: outputs are 0 on the next edge and no out_last is emitted for the aborted message.
- Back-to-back datagrams: a byte following an in_last byte with no idle cycle is parsed from the start state.

## Configuration
- MOLD_HDR_EN defined:
  - The HDR state exists; the 20-byte MoldUDP64 header is parsed.
  - seq_valid, seq_num and msg_count are driven.
- MOLD_HDR_EN undefined:
  - The HDR logic is removed; the payload begins directly with a length prefix.
  - seq_valid, seq_num and msg_count are tied to 0.

## Test plan
- **Single message (MOLD_HDR_EN):** header with seq 0x0000_0000_0000_1234 and count 1, then length 0x000C and a 12-byte 'A' (0x41) message with in_last on the final byte.
  - seq_valid pulses once with seq_num=0x1234 and msg_count=1.
  - 12 out_valid bytes, out_first on idx 0, out_type=0x41, out_len=12, out_last on idx 11.
  - No errors.
- **Back-to-back messages with in_valid gaps:** lengths 3 and 2.
  - Two frames are emitted.
  - Idle cycles produce no output and no index change.
- **Truncation:** length 10, but in_last on body byte 4 (idx 4).
  - out_last=1 with out_idx=4 and an err_trunc pulse.
  - The next datagram parses normally.
- **Oversize length:** length 300 with MAX_MSG_LEN=64.
  - err_len pulses and no output until in_last.
  - A following datagram frames correctly.
- **Zero length and heartbeat:** length 0x0000 followed by length 1.
  - Only the 1-byte message is emitted.
  - A 20-byte header-only datagram gives seq_valid and no errors.
- **Mid-message reset:** reset low for 1 cycle at body idx 5.
  - All outputs are 0 and no out_last.
  - A fresh datagram framed correctly afterwards.
